// File: rtl/carfield_dbg_sba_pkg.sv
// -----------------------------------------------------------------------------
// carfield_dbg_sba_pkg
// Shared definitions for the debug-module system-bus-access responder:
//   - DMI register addresses (SBCS, SBAddress0, SBData0) and DMI op codes
//   - sbcs_t : packed layout of the SBCS register as seen on a DMI read
//   - sberror codes reported in SBCS.sberror
//   - sba_state_e : bus-master FSM states
// -----------------------------------------------------------------------------
package carfield_dbg_sba_pkg;

    localparam logic [6:0] DMI_SBCS    = 7'h38;
    localparam logic [6:0] DMI_SBADDR0 = 7'h39;
    localparam logic [6:0] DMI_SBDATA0 = 7'h3C;

    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [2:0] SBVERSION   = 3'd1;
    localparam logic [2:0] SBACCESS_32 = 3'd2;
    // Only 32-bit accesses are supported (sbaccess32 capability bit).
    localparam logic [4:0] SBACCESS_CAPS = 5'b00100;

    localparam logic [2:0] SBERR_NONE  = 3'd0;
    localparam logic [2:0] SBERR_ALIGN = 3'd3;
    localparam logic [2:0] SBERR_SIZE  = 3'd4;
    localparam logic [2:0] SBERR_BUS   = 3'd7;

    typedef struct packed {
        logic [2:0] sbversion;        // [31:29]
        logic [5:0] reserved;         // [28:23]
        logic       sbbusyerror;      // [22]
        logic       sbbusy;           // [21]
        logic       sbreadonaddr;     // [20]
        logic [2:0] sbaccess;         // [19:17]
        logic       sbautoincrement;  // [16]
        logic       sbreadondata;     // [15]
        logic [2:0] sberror;          // [14:12]
        logic [6:0] sbasize;          // [11:5]
        logic [4:0] sbaccess_caps;    // [4:0]
    } sbcs_t;

    typedef enum logic [1:0] {
        SBA_IDLE = 2'd0,
        SBA_REQ  = 2'd1,
        SBA_WAIT = 2'd2
    } sba_state_e;

endpackage

// File: rtl/carfield_dmi_sba.sv
// -----------------------------------------------------------------------------
// carfield_dmi_sba
// System-bus-access responder behind the DMI port. Serves DMI requests to
// SBCS, SBAddress0 and SBData0 and turns them into 32-bit accesses on a
// req/gnt/rvalid bus master port (autoincrement, read-on-address,
// read-on-data, busy detection, sticky errors).
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   dmi_req_*                DMI request (valid/ready, addr, op, data)
//   dmi_resp_*               DMI response (valid/ready, data, op=0)
//   sb_req_o/sb_gnt_i        bus request / grant
//   sb_we_o, sb_addr_o,
//   sb_wdata_o, sb_be_o      access attributes, stable while requesting
//   sb_rvalid_i, sb_rdata_i,
//   sb_err_i                 bus response (error qualified by rvalid)
// -----------------------------------------------------------------------------
module carfield_dmi_sba
    import carfield_dbg_sba_pkg::*;
#(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 dmi_req_valid_i,
    output logic                 dmi_req_ready_o,
    input  logic [6:0]           dmi_req_addr_i,
    input  logic [1:0]           dmi_req_op_i,
    input  logic [31:0]          dmi_req_data_i,

    output logic                 dmi_resp_valid_o,
    input  logic                 dmi_resp_ready_i,
    output logic [31:0]          dmi_resp_data_o,
    output logic [1:0]           dmi_resp_op_o,

    output logic                 sb_req_o,
    input  logic                 sb_gnt_i,
    output logic                 sb_we_o,
    output logic [AddrWidth-1:0] sb_addr_o,
    output logic [31:0]          sb_wdata_o,
    output logic [3:0]           sb_be_o,
    input  logic                 sb_rvalid_i,
    input  logic [31:0]          sb_rdata_i,
    input  logic                 sb_err_i
);

    sba_state_e r_state, w_state_next;

    logic [AddrWidth-1:0] r_addr;
    logic [31:0]          r_data;
    logic                 r_we;
    logic                 r_readonaddr;
    logic [2:0]           r_access;
    logic                 r_autoinc;
    logic                 r_readondata;
    logic [2:0]           r_sberror;
    logic                 r_busyerror;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_data;

    logic                 w_accept;
    logic                 w_busy;
    logic                 w_wr_sbcs;
    logic                 w_wr_addr;
    logic                 w_wr_data;
    logic                 w_rd_data;
    logic                 w_busy_hit;
    logic                 w_trig;
    logic                 w_start;
    logic                 w_done;
    logic [2:0]           w_pre_err;
    logic [AddrWidth-1:0] w_start_addr;
    logic [31:0]          w_addr_ext;
    logic [31:0]          w_rd_val;
    sbcs_t                w_sbcs;

    // -------------------------------------------------------------------------
    // Request decode and access-start qualification
    // -------------------------------------------------------------------------
    always_comb begin
        w_accept   = dmi_req_valid_i & ~r_resp_valid;
        w_busy     = (r_state != SBA_IDLE);
        w_wr_sbcs  = w_accept && (dmi_req_op_i == DMI_OP_WRITE) && (dmi_req_addr_i == DMI_SBCS);
        w_wr_addr  = w_accept && (dmi_req_op_i == DMI_OP_WRITE) && (dmi_req_addr_i == DMI_SBADDR0);
        w_wr_data  = w_accept && (dmi_req_op_i == DMI_OP_WRITE) && (dmi_req_addr_i == DMI_SBDATA0);
        w_rd_data  = w_accept && (dmi_req_op_i == DMI_OP_READ)  && (dmi_req_addr_i == DMI_SBDATA0);
        w_busy_hit = w_busy && (w_wr_addr || w_wr_data || w_rd_data);

        // A pending sticky error inhibits new accesses but not register loads.
        w_trig = !w_busy && (r_sberror == SBERR_NONE) && !r_busyerror &&
                 ((w_wr_addr && r_readonaddr) || w_wr_data || (w_rd_data && r_readondata));

        // Read-on-address uses the address being written this cycle.
        w_start_addr = w_wr_addr ? dmi_req_data_i[AddrWidth-1:0] : r_addr;

        w_pre_err = SBERR_NONE;
        if (r_access != SBACCESS_32) begin
            w_pre_err = SBERR_SIZE;
        end else if (w_start_addr[1:0] != 2'b00) begin
            w_pre_err = SBERR_ALIGN;
        end
        w_start = w_trig && (w_pre_err == SBERR_NONE);

        w_done = (r_state == SBA_WAIT) && sb_rvalid_i;
    end

    // -------------------------------------------------------------------------
    // DMI read data mux
    // -------------------------------------------------------------------------
    always_comb begin
        w_addr_ext = '0;
        w_addr_ext[AddrWidth-1:0] = r_addr;

        w_sbcs                 = '0;
        w_sbcs.sbversion       = SBVERSION;
        w_sbcs.sbbusyerror     = r_busyerror;
        w_sbcs.sbbusy          = w_busy;
        w_sbcs.sbreadonaddr    = r_readonaddr;
        w_sbcs.sbaccess        = r_access;
        w_sbcs.sbautoincrement = r_autoinc;
        w_sbcs.sbreadondata    = r_readondata;
        w_sbcs.sberror         = r_sberror;
        w_sbcs.sbasize         = 7'(AddrWidth);
        w_sbcs.sbaccess_caps   = SBACCESS_CAPS;

        w_rd_val = '0;
        if (dmi_req_op_i == DMI_OP_READ) begin
            case (dmi_req_addr_i)
                DMI_SBCS:    w_rd_val = w_sbcs;
                DMI_SBADDR0: w_rd_val = w_addr_ext;
                DMI_SBDATA0: w_rd_val = r_data;
                default:     w_rd_val = '0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus master FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SBA_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        sb_req_o     = 1'b0;
        case (r_state)
            SBA_IDLE: begin
                if (w_start) begin
                    w_state_next = SBA_REQ;
                end
            end
            SBA_REQ: begin
                sb_req_o = 1'b1;
                if (sb_gnt_i) begin
                    w_state_next = SBA_WAIT;
                end
            end
            SBA_WAIT: begin
                if (sb_rvalid_i) begin
                    w_state_next = SBA_IDLE;
                end
            end
            default: begin
                w_state_next = SBA_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Register file and response register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_readonaddr <= 1'b0;
            r_access     <= SBACCESS_32;
            r_autoinc    <= 1'b0;
            r_readondata <= 1'b0;
            r_sberror    <= SBERR_NONE;
            r_busyerror  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= w_rd_val;
            end else if (r_resp_valid && dmi_resp_ready_i) begin
                r_resp_valid <= 1'b0;
            end

            if (w_wr_sbcs) begin
                r_busyerror  <= r_busyerror & ~dmi_req_data_i[22];
                r_readonaddr <= dmi_req_data_i[20];
                r_access     <= dmi_req_data_i[19:17];
                r_autoinc    <= dmi_req_data_i[16];
                r_readondata <= dmi_req_data_i[15];
                r_sberror    <= r_sberror & ~dmi_req_data_i[14:12];
            end

            if (w_busy_hit) begin
                r_busyerror <= 1'b1;
            end

            if (w_wr_addr && !w_busy) begin
                r_addr <= dmi_req_data_i[AddrWidth-1:0];
            end
            if (w_wr_data && !w_busy) begin
                r_data <= dmi_req_data_i;
            end

            if (w_start) begin
                r_we <= w_wr_data;
            end
            if (w_trig && !w_start) begin
                r_sberror <= w_pre_err;
            end

            // Completion comes last so an error set wins over a same-cycle W1C.
            if (w_done) begin
                if (sb_err_i) begin
                    r_sberror <= SBERR_BUS;
                end else begin
                    if (!r_we) begin
                        r_data <= sb_rdata_i;
                    end
                    if (r_autoinc) begin
                        r_addr <= r_addr + AddrWidth'(4);
                    end
                end
            end
        end
    end

    assign dmi_req_ready_o  = ~r_resp_valid;
    assign dmi_resp_valid_o = r_resp_valid;
    assign dmi_resp_data_o  = r_resp_data;
    assign dmi_resp_op_o    = 2'b00;

    assign sb_we_o    = r_we;
    assign sb_addr_o  = r_addr;
    assign sb_wdata_o = r_data;
    assign sb_be_o    = 4'hF;

endmodule

// File: tb/tb_carfield_dmi_sba.sv
// -----------------------------------------------------------------------------
// tb_carfield_dmi_sba
// Directed bench for carfield_dmi_sba: DMI driver tasks, a small bus
// responder with configurable grant hold-off, response delay and error
// injection, and hand-computed expected register values.
// -----------------------------------------------------------------------------
module tb_carfield_dmi_sba;

    localparam logic [6:0] A_SBCS  = 7'h38;
    localparam logic [6:0] A_ADDR0 = 7'h39;
    localparam logic [6:0] A_DATA0 = 7'h3C;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmi_req_valid_i = 1'b0;
    logic        dmi_req_ready_o;
    logic [6:0]  dmi_req_addr_i = '0;
    logic [1:0]  dmi_req_op_i = '0;
    logic [31:0] dmi_req_data_i = '0;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i = 1'b0;
    logic [31:0] dmi_resp_data_o;
    logic [1:0]  dmi_resp_op_o;
    logic        sb_req_o;
    logic        sb_gnt_i = 1'b0;
    logic        sb_we_o;
    logic [31:0] sb_addr_o;
    logic [31:0] sb_wdata_o;
    logic [3:0]  sb_be_o;
    logic        sb_rvalid_i = 1'b0;
    logic [31:0] sb_rdata_i = '0;
    logic        sb_err_i = 1'b0;

    carfield_dmi_sba #(.AddrWidth(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .dmi_req_valid_i (dmi_req_valid_i),
        .dmi_req_ready_o (dmi_req_ready_o),
        .dmi_req_addr_i  (dmi_req_addr_i),
        .dmi_req_op_i    (dmi_req_op_i),
        .dmi_req_data_i  (dmi_req_data_i),
        .dmi_resp_valid_o(dmi_resp_valid_o),
        .dmi_resp_ready_i(dmi_resp_ready_i),
        .dmi_resp_data_o (dmi_resp_data_o),
        .dmi_resp_op_o   (dmi_resp_op_o),
        .sb_req_o        (sb_req_o),
        .sb_gnt_i        (sb_gnt_i),
        .sb_we_o         (sb_we_o),
        .sb_addr_o       (sb_addr_o),
        .sb_wdata_o      (sb_wdata_o),
        .sb_be_o         (sb_be_o),
        .sb_rvalid_i     (sb_rvalid_i),
        .sb_rdata_i      (sb_rdata_i),
        .sb_err_i        (sb_err_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- bus responder ----------------
    int          gnt_hold   = 0;   // cycles of req before grant
    int          resp_delay = 0;   // extra cycles between grant and rvalid
    logic        err_cfg    = 1'b0;
    int          hold_cnt   = 0;
    logic        pend       = 1'b0;
    int          dly_cnt    = 0;
    logic [31:0] pend_rdata = '0;
    logic        pend_err   = 1'b0;
    int          wr_cnt     = 0;
    int          rd_cnt     = 0;
    logic [31:0] wr_addr_log [16];
    logic [31:0] wr_data_log [16];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h10) return 32'hA;
        if (a == 32'h14) return 32'hB;
        return a ^ 32'h5A5A0000;
    endfunction

    always @(negedge clk) begin
        sb_gnt_i    = 1'b0;
        sb_rvalid_i = 1'b0;
        sb_err_i    = 1'b0;
        sb_rdata_i  = '0;
        if (pend) begin
            if (dly_cnt > 0) begin
                dly_cnt--;
            end else begin
                sb_rvalid_i = 1'b1;
                sb_rdata_i  = pend_rdata;
                sb_err_i    = pend_err;
                pend        = 1'b0;
            end
        end else if (sb_req_o) begin
            if (hold_cnt < gnt_hold) begin
                hold_cnt++;
            end else begin
                hold_cnt = 0;
                sb_gnt_i = 1'b1;
                pend     = 1'b1;
                dly_cnt  = resp_delay;
                pend_err = err_cfg;
                if (sb_we_o) begin
                    if (wr_cnt < 16) begin
                        wr_addr_log[wr_cnt] = sb_addr_o;
                        wr_data_log[wr_cnt] = sb_wdata_o;
                    end
                    wr_cnt++;
                end else begin
                    pend_rdata = mem_rd(sb_addr_o);
                    rd_cnt++;
                end
            end
        end
    end

    // ---------------- DMI driver ----------------
    task automatic dmi_send(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        int n;
        @(negedge clk);
        dmi_req_valid_i = 1'b1;
        dmi_req_addr_i  = a;
        dmi_req_op_i    = op;
        dmi_req_data_i  = d;
        n = 0;
        while (!dmi_req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("dmi_req_timeout", 32'(dmi_req_ready_o), 32'd1);
        @(negedge clk);
        dmi_req_valid_i = 1'b0;
        dmi_req_op_i    = 2'd0;
    endtask

    task automatic dmi_recv(output logic [31:0] d);
        int n;
        n = 0;
        while (!dmi_resp_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("dmi_resp_timeout", 32'(dmi_resp_valid_o), 32'd1);
        d = dmi_resp_data_o;
        dmi_resp_ready_i = 1'b1;
        @(negedge clk);
        dmi_resp_ready_i = 1'b0;
    endtask

    task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        dmi_send(a, 2'd2, d);
        dmi_recv(dummy);
    endtask

    task automatic dmi_rd(input logic [6:0] a, output logic [31:0] d);
        dmi_send(a, 2'd1, 32'h0);
        dmi_recv(d);
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        v = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            dmi_rd(A_SBCS, v);
            if (!v[21]) break;
        end
        if (v[21]) chk("idle_timeout", 32'(v[21]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    logic [31:0] rv;
    int          wc0;

    initial begin
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // Reset state
        chk("rst_req", 32'(sb_req_o), 32'd0);
        chk("rst_resp_valid", 32'(dmi_resp_valid_o), 32'd0);
        dmi_rd(A_SBCS, rv);
        chk("rst_sbcs", rv, 32'h20040404);

        // Configure and read back
        dmi_wr(A_SBCS, 32'h00058000);
        dmi_rd(A_SBCS, rv);
        chk("cfg_sbcs", rv, 32'h20058404);

        // Autoincrement write burst, with write latency checks
        wc0 = wr_cnt;
        dmi_wr(A_ADDR0, 32'h1C000000);
        dmi_send(A_DATA0, 2'd2, 32'hDEADBEEF);
        chk("wlat_resp_valid", 32'(dmi_resp_valid_o), 32'd1);
        chk("wlat_req", 32'(sb_req_o), 32'd1);
        chk("wlat_we", 32'(sb_we_o), 32'd1);
        chk("wlat_be", 32'(sb_be_o), 32'hF);
        dmi_recv(rv);
        chk("wr_resp_data", rv, 32'h0);
        wait_idle();
        dmi_wr(A_DATA0, 32'h12345678);
        wait_idle();
        chk("burst_cnt", 32'(wr_cnt - wc0), 32'd2);
        chk("burst_a0", wr_addr_log[wc0], 32'h1C000000);
        chk("burst_d0", wr_data_log[wc0], 32'hDEADBEEF);
        chk("burst_a1", wr_addr_log[wc0+1], 32'h1C000004);
        chk("burst_d1", wr_data_log[wc0+1], 32'h12345678);
        dmi_rd(A_ADDR0, rv);
        chk("burst_addr_end", rv, 32'h1C000008);

        // Read-on-address then read-on-data
        dmi_wr(A_SBCS, 32'h00158000);
        dmi_wr(A_ADDR0, 32'h10);
        wait_idle();
        dmi_rd(A_DATA0, rv);
        chk("rod_first", rv, 32'hA);
        wait_idle();
        dmi_rd(A_DATA0, rv);
        chk("rod_second", rv, 32'hB);
        wait_idle();
        dmi_rd(A_ADDR0, rv);
        chk("rod_addr", rv, 32'h1C);

        // Busy error with grant withheld
        dmi_wr(A_SBCS, 32'h00058000);
        dmi_wr(A_ADDR0, 32'h100);
        gnt_hold = 20;
        wc0 = wr_cnt;
        dmi_wr(A_DATA0, 32'h11111111);
        dmi_wr(A_DATA0, 32'h22222222);
        dmi_rd(A_SBCS, rv);
        chk("busy_sbcs", rv, 32'h20658404);
        wait_idle();
        gnt_hold = 0;
        chk("busy_wr_cnt", 32'(wr_cnt - wc0), 32'd1);
        chk("busy_wr_data", wr_data_log[wc0], 32'h11111111);
        dmi_rd(A_ADDR0, rv);
        chk("busy_addr", rv, 32'h104);
        dmi_rd(A_SBCS, rv);
        chk("busy_sticky", rv, 32'h20458404);
        dmi_wr(A_SBCS, 32'h00458000);
        dmi_rd(A_SBCS, rv);
        chk("busy_w1c", rv, 32'h20058404);

        // Misaligned read-on-address, then inhibit
        dmi_wr(A_SBCS, 32'h00158000);
        wc0 = wr_cnt;
        dmi_send(A_ADDR0, 2'd2, 32'h2);
        chk("align_no_req", 32'(sb_req_o), 32'd0);
        dmi_recv(rv);
        dmi_rd(A_SBCS, rv);
        chk("align_sbcs", rv, 32'h2015B404);
        dmi_send(A_DATA0, 2'd2, 32'h5);
        chk("inhibit_no_req", 32'(sb_req_o), 32'd0);
        dmi_recv(rv);
        repeat (4) @(negedge clk);
        chk("inhibit_wr_cnt", 32'(wr_cnt - wc0), 32'd0);
        dmi_wr(A_SBCS, 32'h00003000);
        dmi_rd(A_SBCS, rv);
        chk("align_clear", rv, 32'h20000404);

        // Bus error on read: sberror=7, no increment
        dmi_wr(A_SBCS, 32'h00158000);
        err_cfg = 1'b1;
        dmi_wr(A_ADDR0, 32'h40);
        wait_idle();
        err_cfg = 1'b0;
        dmi_rd(A_SBCS, rv);
        chk("berr_sbcs", rv, 32'h2015F404);
        dmi_rd(A_ADDR0, rv);
        chk("berr_addr", rv, 32'h40);

        // Reset while waiting for the bus response; late rvalid ignored
        dmi_wr(A_SBCS, 32'h00157000);
        resp_delay = 10;
        dmi_wr(A_ADDR0, 32'h80);
        repeat (2) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req", 32'(sb_req_o), 32'd0);
        chk("mid_rst_resp", 32'(dmi_resp_valid_o), 32'd0);
        chk("mid_rst_we", 32'(sb_we_o), 32'd0);
        chk("mid_rst_addr", sb_addr_o, 32'h0);
        chk("mid_rst_wdata", sb_wdata_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (15) @(negedge clk);
        resp_delay = 0;
        dmi_rd(A_SBCS, rv);
        chk("post_rst_sbcs", rv, 32'h20040404);
        dmi_rd(A_DATA0, rv);
        chk("post_rst_data", rv, 32'h0);
        dmi_rd(A_ADDR0, rv);
        chk("post_rst_addr", rv, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
